// File: rtl/aes_fifo_dispatch.sv
// AES core front end: host jobs queue in an input FIFO, are issued one at a time, and results queue for host reads.
// Reads answer one cycle after arvalid_q and hold until rready; pushes into a full input FIFO are dropped and flagged.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8,
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Full/empty come from the registered count, so both are cycle-start values.
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end
endmodule

module aes_fifo_dispatch #(
    parameter int          KEY_W     = 4,
    parameter int          DATA_W    = 4,
    parameter int          RES_W     = 5,
    parameter int          IN_DEPTH  = 8,
    parameter int          OUT_DEPTH = 8,
    parameter int          TIMEOUT   = 255,
    parameter logic [31:0] DATA_ADDR = 32'h0000_0500,
    parameter logic [31:0] STAT_ADDR = 32'h0000_0504,
    parameter logic [31:0] CTRL_ADDR = 32'h0000_0508,
    parameter logic [31:0] UNIMP_VAL = 32'hDEAD_BEEF
) (
    input  logic              clk_main_a0,
    input  logic              rst_main,
    input  logic              wready,
    input  logic [31:0]       wr_addr,
    input  logic [31:0]       wdata,
    input  logic              arvalid_q,
    input  logic [31:0]       araddr_q,
    input  logic              rready,
    output logic              rvalid,
    output logic [31:0]       rdata,
    output logic [1:0]        rresp,
    output logic [KEY_W-1:0]  core_key,
    output logic [DATA_W-1:0] core_din,
    output logic              core_start,
    input  logic [RES_W-1:0]  core_dout,
    input  logic              core_vld
);
    localparam int JOB_W = KEY_W + DATA_W;
    localparam int ICW   = $clog2(IN_DEPTH + 1);
    localparam int OCW   = $clog2(OUT_DEPTH + 1);
    localparam int TW    = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [1:0]       state;
    logic [TW-1:0]    timer;
    logic             drop_flag;
    logic             undr_flag;
    logic             tout_flag;

    logic             wr_data;
    logic             wr_ctrl;
    logic             flush;
    logic             clr_flags;
    logic             unused_bits;

    logic             in_pop;
    logic             in_full;
    logic             in_empty;
    logic [JOB_W-1:0] in_head;
    logic [ICW-1:0]   in_count;

    logic             out_push;
    logic             out_pop;
    logic             out_full;
    logic             out_empty;
    logic [RES_W-1:0] out_head;
    logic [OCW-1:0]   out_count;

    logic             rd_take;
    logic             rd_new;
    logic             rd_is_data;
    logic [31:0]      stat_word;
    logic             timer_last;
    logic             drop_set;
    logic             undr_set;
    logic             tout_set;

    assign wr_data     = wready && (wr_addr == DATA_ADDR);
    assign wr_ctrl     = wready && (wr_addr == CTRL_ADDR);
    assign flush       = wr_ctrl && wdata[1];
    assign clr_flags   = wr_ctrl && wdata[0];
    assign unused_bits = ^(wdata >> JOB_W);

    assign rd_take    = rvalid && rready;
    assign rd_new     = arvalid_q && !rvalid && !rd_take;
    assign rd_is_data = (araddr_q == DATA_ADDR);

    assign in_pop     = (state == S_ISSUE);
    assign out_push   = (state == S_WAIT) && core_vld;
    assign out_pop    = rd_new && rd_is_data;
    assign timer_last = (timer == TW'(TIMEOUT - 1));

    assign drop_set = wr_data && in_full;
    assign undr_set = rd_new && rd_is_data && out_empty;
    assign tout_set = (state == S_WAIT) && !core_vld && timer_last;

    sync_fifo #(.W(JOB_W), .DEPTH(IN_DEPTH)) u_in_fifo (
        .clk      (clk_main_a0),
        .rst      (rst_main),
        .flush    (flush),
        .push     (wr_data),
        .push_dat (wdata[JOB_W-1:0]),
        .pop      (in_pop),
        .head     (in_head),
        .count    (in_count),
        .full     (in_full),
        .empty    (in_empty)
    );

    sync_fifo #(.W(RES_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
        .clk      (clk_main_a0),
        .rst      (rst_main),
        .flush    (flush),
        .push     (out_push),
        .push_dat (core_dout),
        .pop      (out_pop),
        .head     (out_head),
        .count    (out_count),
        .full     (out_full),
        .empty    (out_empty)
    );

    always_comb begin
        stat_word        = '0;
        stat_word[7:0]   = 8'(in_count);
        stat_word[15:8]  = 8'(out_count);
        stat_word[16]    = (state != S_IDLE);
        stat_word[17]    = in_full;
        stat_word[18]    = out_empty;
        stat_word[29]    = drop_flag;
        stat_word[30]    = undr_flag;
        stat_word[31]    = tout_flag;
    end

    always_ff @(posedge clk_main_a0 or posedge rst_main) begin
        if (rst_main) begin
            state      <= S_IDLE;
            timer      <= '0;
            core_key   <= '0;
            core_din   <= '0;
            core_start <= 1'b0;
        end else begin
            core_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Reserving an out-FIFO slot here keeps the result push from ever overflowing.
                    if (!in_empty && !out_full) begin
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (in_empty) begin
                        state <= S_IDLE;
                    end else begin
                        core_key   <= in_head[KEY_W-1:0];
                        core_din   <= in_head[JOB_W-1:KEY_W];
                        core_start <= 1'b1;
                        timer      <= '0;
                        state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (core_vld || timer_last) begin
                        state <= S_IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_main_a0 or posedge rst_main) begin
        if (rst_main) begin
            drop_flag <= 1'b0;
            undr_flag <= 1'b0;
            tout_flag <= 1'b0;
        end else begin
            if (clr_flags) begin
                drop_flag <= 1'b0;
                undr_flag <= 1'b0;
                tout_flag <= 1'b0;
            end
            if (drop_set) begin
                drop_flag <= 1'b1;
            end
            if (undr_set) begin
                undr_flag <= 1'b1;
            end
            if (tout_set) begin
                tout_flag <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_main_a0 or posedge rst_main) begin
        if (rst_main) begin
            rvalid <= 1'b0;
            rdata  <= '0;
            rresp  <= 2'b00;
        end else if (rd_take) begin
            rvalid <= 1'b0;
            rdata  <= '0;
            rresp  <= 2'b00;
        end else if (rd_new) begin
            rvalid <= 1'b1;
            if (rd_is_data) begin
                if (!out_empty) begin
                    rdata <= 32'(out_head);
                    rresp <= 2'b00;
                end else begin
                    rdata <= 32'hDEAD_0000;
                    rresp <= 2'b10;
                end
            end else if (araddr_q == STAT_ADDR) begin
                rdata <= stat_word;
                rresp <= 2'b00;
            end else begin
                rdata <= UNIMP_VAL;
                rresp <= 2'b00;
            end
        end
    end
endmodule

// File: tb/tb_aes_fifo_dispatch.sv
// Bench for aes_fifo_dispatch: queue-level reference model plus a bench-driven core with random latency.
`timescale 1ns/1ps
module tb_aes_fifo_dispatch;
    localparam int KEY_W     = 4;
    localparam int DATA_W    = 4;
    localparam int RES_W     = 5;
    localparam int IN_DEPTH  = 8;
    localparam int OUT_DEPTH = 8;
    localparam int TIMEOUT   = 4;
    localparam int JOB_W     = KEY_W + DATA_W;
    localparam logic [31:0] DATA_ADDR = 32'h0000_0500;
    localparam logic [31:0] STAT_ADDR = 32'h0000_0504;
    localparam logic [31:0] CTRL_ADDR = 32'h0000_0508;
    localparam logic [31:0] UNIMP_VAL = 32'hDEAD_BEEF;

    logic              clk_main_a0 = 1'b0;
    logic              rst_main;
    logic              wready;
    logic [31:0]       wr_addr;
    logic [31:0]       wdata;
    logic              arvalid_q;
    logic [31:0]       araddr_q;
    logic              rready;
    logic              rvalid;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic [KEY_W-1:0]  core_key;
    logic [DATA_W-1:0] core_din;
    logic              core_start;
    logic [RES_W-1:0]  core_dout;
    logic              core_vld;

    aes_fifo_dispatch #(
        .KEY_W(KEY_W), .DATA_W(DATA_W), .RES_W(RES_W),
        .IN_DEPTH(IN_DEPTH), .OUT_DEPTH(OUT_DEPTH), .TIMEOUT(TIMEOUT),
        .DATA_ADDR(DATA_ADDR), .STAT_ADDR(STAT_ADDR), .CTRL_ADDR(CTRL_ADDR), .UNIMP_VAL(UNIMP_VAL)
    ) dut (
        .clk_main_a0(clk_main_a0), .rst_main(rst_main),
        .wready(wready), .wr_addr(wr_addr), .wdata(wdata),
        .arvalid_q(arvalid_q), .araddr_q(araddr_q), .rready(rready),
        .rvalid(rvalid), .rdata(rdata), .rresp(rresp),
        .core_key(core_key), .core_din(core_din), .core_start(core_start),
        .core_dout(core_dout), .core_vld(core_vld)
    );

    always #5 clk_main_a0 = ~clk_main_a0;

    // Reference model: job/result queues and sticky flags.
    logic [JOB_W-1:0] in_q[$];
    logic [RES_W-1:0] out_q[$];
    bit m_drop, m_undr, m_tout;
    int core_mode;   // 0 random latency with occasional stall, 1 fixed 0x13 after 3 cycles, 2 stall
    int n_checks = 0;
    int n_errors = 0;
    int n_starts = 0;
    int last_gap = 0;
    int last_start = 0;
    int cyc = 0;

    always @(posedge clk_main_a0) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_stat();
        logic [31:0] e = '0;
        e[7:0]  = 8'(in_q.size());
        e[15:8] = 8'(out_q.size());
        e[17]   = (in_q.size() == IN_DEPTH);
        e[18]   = (out_q.size() == 0);
        e[29]   = m_drop;
        e[30]   = m_undr;
        e[31]   = m_tout;
        return e;
    endfunction

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        wready = 1'b1; wr_addr = a; wdata = d;
        @(posedge clk_main_a0); #1;
        wready = 1'b0; wr_addr = $urandom; wdata = $urandom;
    endtask

    task automatic push_job(input logic [31:0] d);
        if (in_q.size() == IN_DEPTH) m_drop = 1'b1;
        else in_q.push_back(d[JOB_W-1:0]);
        wr(DATA_ADDR, d);
    endtask

    task automatic ctrl(input logic [31:0] v);
        wr(CTRL_ADDR, v);
        if (v[0]) begin m_drop = 0; m_undr = 0; m_tout = 0; end
        if (v[1]) begin in_q.delete(); out_q.delete(); end
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
        arvalid_q = 1'b1; araddr_q = a; rready = 1'b0;
        @(posedge clk_main_a0); #1;
        arvalid_q = 1'b0; araddr_q = $urandom;
        chk("rvalid_rise", 32'(rvalid), 32'd1);
        repeat ($urandom_range(0, 2)) begin @(posedge clk_main_a0); #1; end
        d = rdata; r = rresp;
        rready = 1'b1;
        @(posedge clk_main_a0); #1;
        rready = 1'b0;
        chk("rvalid_clear", 32'(rvalid), 32'd0);
        chk("rdata_clear", rdata, 32'd0);
    endtask

    task automatic read_data(input string tag);
        logic [31:0] d, ed;
        logic [1:0]  r, er;
        if (out_q.size() > 0) begin ed = 32'(out_q.pop_front()); er = 2'b00; end
        else begin ed = 32'hDEAD_0000; er = 2'b10; m_undr = 1'b1; end
        do_read(DATA_ADDR, d, r);
        chk({tag, "_rdata"}, d, ed);
        chk({tag, "_rresp"}, 32'(r), 32'(er));
    endtask

    task automatic read_stat(input string tag);
        logic [31:0] d;
        logic [1:0]  r;
        do_read(STAT_ADDR, d, r);
        chk(tag, d, exp_stat());
        chk({tag, "_rresp"}, 32'(r), 32'd0);
    endtask

    task automatic settle();
        repeat (8 * (in_q.size() + 1) + 6) @(posedge clk_main_a0);
        #1;
    endtask

    // Bench-side AES core: checks each issued job against the model queue and answers it.
    initial begin : core_model
        logic [JOB_W-1:0] job;
        logic [RES_W-1:0] res;
        int lat;
        bit stall;
        core_vld = 1'b0; core_dout = '0;
        forever begin
            @(posedge clk_main_a0); #1;
            if (core_start && !rst_main) begin
                n_starts++;
                last_gap = cyc - last_start;
                last_start = cyc;
                if (in_q.size() == 0) chk("spurious_start", 32'(core_start), 32'd0);
                else begin
                    job = in_q.pop_front();
                    chk("core_key", 32'(core_key), 32'(job[KEY_W-1:0]));
                    chk("core_din", 32'(core_din), 32'(job[JOB_W-1:KEY_W]));
                end
                case (core_mode)
                    1: begin stall = 0; lat = 3; res = 5'h13; end
                    2: begin stall = 1; lat = 1; res = '0; end
                    default: begin
                        stall = ($urandom_range(0, 7) == 0);
                        lat = $urandom_range(1, TIMEOUT - 1);
                        res = RES_W'($urandom);
                    end
                endcase
                @(posedge clk_main_a0); #1;
                chk("start_pulse", 32'(core_start), 32'd0);
                if (stall) m_tout = 1'b1;
                else begin
                    repeat (lat - 1) begin @(posedge clk_main_a0); #1; end
                    core_vld = 1'b1; core_dout = res; out_q.push_back(res);
                    @(posedge clk_main_a0); #1;
                    core_vld = 1'b0; core_dout = RES_W'($urandom);
                end
            end
        end
    end

    initial begin : watchdog
        #600000;
        n_errors++;
        $display("FAIL watchdog: observed no completion, required finish within 60000 cycles");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int starts0;
        logic [31:0] a, d;
        logic [1:0]  r;
        rst_main = 1'b1; wready = 1'b0; wr_addr = '0; wdata = '0;
        arvalid_q = 1'b0; araddr_q = '0; rready = 1'b0; core_mode = 0;
        repeat (3) @(posedge clk_main_a0); #1;
        chk("rst_core_start", 32'(core_start), 32'd0);
        chk("rst_core_key", 32'(core_key), 32'd0);
        chk("rst_core_din", 32'(core_din), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_rresp", 32'(rresp), 32'd0);
        rst_main = 1'b0;
        @(posedge clk_main_a0); #1;
        read_stat("stat_after_reset");

        // Single job 0x21: key 1, data 2, core answers 0x13 at the last legal WAIT cycle.
        core_mode = 1;
        push_job(32'h0000_0021);
        settle();
        chk("job21_starts", 32'(n_starts), 32'd1);
        read_data("job21");
        read_stat("stat_job21");

        read_data("underflow");
        read_stat("stat_undr");
        ctrl(32'h1);
        read_stat("stat_undr_clr");

        // Stalled core: each job leaves WAIT after TIMEOUT cycles and the next issues.
        core_mode = 2;
        push_job($urandom);
        push_job($urandom);
        settle();
        chk("timeout_gap", 32'(last_gap), 32'(TIMEOUT + 2));
        read_stat("stat_tout");
        ctrl(32'h1);

        // Fill the result FIFO, then overfill the job FIFO.
        core_mode = 0;
        for (int i = 0; i < 40 && out_q.size() < OUT_DEPTH; i++) begin
            push_job($urandom);
            settle();
        end
        starts0 = n_starts;
        for (int i = 0; i < IN_DEPTH + 1; i++) push_job($urandom);
        settle();
        chk("no_issue_when_full", 32'(n_starts), 32'(starts0));
        read_stat("stat_full_drop");
        ctrl(32'h1);
        read_stat("stat_drop_clr");
        core_mode = 1;
        read_data("pop_one");
        settle();
        chk("one_issue_per_pop", 32'(n_starts), 32'(starts0 + 1));
        read_stat("stat_after_one_issue");
        ctrl(32'h2);
        settle();
        read_stat("stat_flush");
        read_data("underflow_after_flush");
        ctrl(32'h1);

        // Random traffic against the model.
        core_mode = 0;
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: push_job($urandom);
                4, 5, 6: read_data("rand_data");
                7: read_stat("rand_stat");
                8: begin
                    a = ($urandom_range(0, 1) == 0) ? CTRL_ADDR : $urandom;
                    if (a == DATA_ADDR || a == STAT_ADDR) a = a ^ 32'h0001_0000;
                    do_read(a, d, r);
                    chk("unmapped_rdata", d, UNIMP_VAL);
                    chk("unmapped_rresp", 32'(r), 32'd0);
                end
                default: begin
                    if ($urandom_range(0, 1) == 0) ctrl(32'h1);
                    else begin
                        a = $urandom;
                        if (a == DATA_ADDR || a == CTRL_ADDR) a = a ^ 32'h0001_0000;
                        wr(a, $urandom);
                    end
                end
            endcase
            settle();
        end
        for (int i = 0; i < 40 && (out_q.size() > 0 || in_q.size() > 0); i++) begin
            read_data("drain");
            settle();
        end
        read_stat("stat_drained");

        // Reset in the middle of WAIT; the core answers after reset is released.
        core_mode = 1;
        push_job(32'h0000_005A);
        for (int i = 0; i < 20 && !core_start; i++) begin
            @(posedge clk_main_a0); #1;
        end
        chk("reset_start_seen", 32'(core_start), 32'd1);
        rst_main = 1'b1;
        #1;
        chk("midrst_core_start", 32'(core_start), 32'd0);
        chk("midrst_core_key", 32'(core_key), 32'd0);
        chk("midrst_core_din", 32'(core_din), 32'd0);
        chk("midrst_rvalid", 32'(rvalid), 32'd0);
        chk("midrst_rdata", rdata, 32'd0);
        chk("midrst_rresp", 32'(rresp), 32'd0);
        @(posedge clk_main_a0); #1;
        rst_main = 1'b0;
        repeat (10) @(posedge clk_main_a0); #1;
        in_q.delete(); out_q.delete();
        m_drop = 0; m_undr = 0; m_tout = 0;
        read_stat("stat_post_reset");
        read_data("late_vld_ignored");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
